// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, default frame size,
// and the idle levels of the serial lines.
package spi_pkg;

    localparam int SPI_DEFAULT_WIDTH = 10;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic SSEL_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_TRAIL
    } spi_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Counts system clocks within one sclk half-period and pulses expire on the
// last cycle of it; wraps to zero on expire so each phase starts fresh.
module spi_halfperiod_timer
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int CW = cnt_width(HALF_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] count;

    assign expire = !clear && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear || expire) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB-first, fixed WIDTH-bit frames. sclk is derived from
// the system clock with a HALF_PERIOD-cycle half-period; all outputs registered.
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_DEFAULT_WIDTH,
    parameter int HALF_PERIOD = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_transmit,
    output logic             busy,
    output logic             data_valid,
    output logic [WIDTH-1:0] data_received,
    output logic             sclk,
    output logic             ssel,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    spi_state_e       state;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [BW-1:0]    bit_cnt;
    logic             timer_clear;
    logic             phase_end;

    // Timer is held in IDLE; every other state change happens on expire,
    // which already returns the count to zero.
    assign timer_clear = (state == ST_IDLE);

    spi_halfperiod_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .expire(phase_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            busy          <= 1'b0;
            data_valid    <= 1'b0;
            data_received <= '0;
            sclk          <= SCLK_IDLE;
            ssel          <= SSEL_IDLE;
            mosi          <= MOSI_IDLE;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The data_valid cycle is itself IDLE; refusing start there
                    // guarantees at least one idle cycle between frames.
                    if (start && !data_valid) begin
                        tx_sr   <= data_transmit;
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        ssel    <= 1'b0;
                        sclk    <= 1'b0;
                        mosi    <= data_transmit[WIDTH-1];
                        busy    <= 1'b1;
                        state   <= ST_LEAD;
                    end
                end
                ST_LEAD, ST_LOW: begin
                    if (phase_end) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[WIDTH-2:0], miso};
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_TRAIL;
                        end else begin
                            tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
                            mosi    <= tx_sr[WIDTH-2];
                            bit_cnt <= bit_cnt + BW'(1);
                            state   <= ST_LOW;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (phase_end) begin
                        ssel          <= SSEL_IDLE;
                        mosi          <= MOSI_IDLE;
                        busy          <= 1'b0;
                        data_valid    <= 1'b1;
                        data_received <= rx_sr;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: vector table plus random frames against
// a frame-level model, and hand sequences for back-to-back and reset cases.
module tb_spi_master;
    import spi_pkg::*;

    localparam int W        = 10;
    localparam int H        = 2;
    localparam int SSEL_LOW = (2 * W + 1) * H;
    localparam int SSEL_LOW1 = (2 * W + 1) * 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic         start, busy, data_valid, sclk, ssel, mosi, miso;
    logic [W-1:0] data_transmit, data_received;
    logic         start1, busy1, data_valid1, sclk1, ssel1, mosi1, miso1;
    logic [W-1:0] data_transmit1, data_received1;

    logic         loop_mode;
    logic         slave_miso;
    logic [W-1:0] slave_tx;
    logic [W-1:0] slave_rx   = '0;
    logic [W-1:0] slave_sh   = '1;
    logic         s_prev_ssel = 1'b1;
    logic         s_prev_sclk = 1'b0;

    assign miso  = loop_mode ? mosi : slave_miso;
    assign miso1 = mosi1;

    spi_master #(.WIDTH(W), .HALF_PERIOD(H)) u_dut (
        .clock(clock), .reset(reset), .start(start), .data_transmit(data_transmit),
        .busy(busy), .data_valid(data_valid), .data_received(data_received),
        .sclk(sclk), .ssel(ssel), .mosi(mosi), .miso(miso)
    );

    spi_master #(.WIDTH(W), .HALF_PERIOD(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .data_transmit(data_transmit1),
        .busy(busy1), .data_valid(data_valid1), .data_received(data_received1),
        .sclk(sclk1), .ssel(ssel1), .mosi(mosi1), .miso(miso1)
    );

    // Slave: loads its word at ssel fall, advances on sclk fall, captures mosi on sclk rise.
    always @(negedge clock) begin
        if (!ssel && s_prev_ssel) begin
            slave_sh = slave_tx;
            slave_rx = '0;
        end else if (!ssel && !sclk && s_prev_sclk) begin
            slave_sh = {slave_sh[W-2:0], 1'b0};
        end
        if (!ssel && sclk && !s_prev_sclk) slave_rx = {slave_rx[W-2:0], mosi};
        slave_miso  = slave_sh[W-1];
        s_prev_ssel = ssel;
        s_prev_sclk = sclk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame on the HALF_PERIOD=2 instance, judged against the frame-level rules.
    task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] sw, input logic lp,
                             input logic poke, input logic [W-1:0] exp_rx,
                             input logic [W-1:0] exp_srx, input string tag);
        int rises, low_cnt, dv_cnt, lat, mosi_bad;
        logic [W-1:0] mosi_word, rx_at_dv;
        logic prev_sclk, prev_mosi;
        rises = 0; low_cnt = 0; dv_cnt = 0; lat = 0; mosi_bad = 0;
        mosi_word = '0; rx_at_dv = '0; prev_sclk = 1'b0; prev_mosi = 1'b1;
        loop_mode = lp;
        slave_tx  = sw;
        @(negedge clock);
        data_transmit = tx;
        start = 1'b1;
        for (int n = 1; n <= SSEL_LOW + 8; n++) begin
            @(negedge clock);
            if (n == 1) begin
                start = 1'b0;
                data_transmit = ~tx;
                check({tag, "_busy_rise"}, busy, 1'b1);
                check({tag, "_first_mosi"}, mosi, tx[W-1]);
            end
            if (poke && n == 10) begin
                start = 1'b1;
                data_transmit = 10'h0F0;
            end
            if (poke && n == 11) start = 1'b0;
            if (!ssel) low_cnt++;
            if (sclk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[W-2:0], mosi};
            end
            if (n > 1 && prev_sclk && sclk && mosi !== prev_mosi) mosi_bad++;
            if (data_valid) begin
                dv_cnt++;
                if (dv_cnt == 1) begin
                    lat = n;
                    rx_at_dv = data_received;
                end
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
        check({tag, "_sclk_rises"}, rises, W);
        check({tag, "_mosi_bits"}, mosi_word, tx);
        check({tag, "_ssel_low"}, low_cnt, SSEL_LOW);
        check({tag, "_dv_count"}, dv_cnt, 1);
        check({tag, "_latency"}, lat, SSEL_LOW + 1);
        check({tag, "_rx"}, rx_at_dv, exp_rx);
        check({tag, "_rx_held"}, data_received, exp_rx);
        check({tag, "_mosi_stable"}, mosi_bad, 0);
        check({tag, "_end_idle"}, {busy, ssel, sclk, mosi}, 4'b0101);
        if (!lp) check({tag, "_slave_rx"}, slave_rx, exp_srx);
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] sw;
        logic         lp;
        logic         poke;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_srx;
    } vec_t;

    vec_t         vecs [6];
    int           n, rises, frames, dv_at, busy_at, low1, idle_ok, dv_late;
    logic         prev, prev_busy1;
    logic [W-1:0] rx1 [2];
    int           lowc [2];
    logic [W-1:0] rtx, rsw;
    logic         rlp;

    initial begin
        start = 1'b0; data_transmit = '0; start1 = 1'b0; data_transmit1 = '0;
        loop_mode = 1'b1; slave_tx = '0;

        // Post-reset idle
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_ssel", ssel, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_dv", data_valid, 1'b0);
        check("rst_rx", data_received, '0);
        idle_ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if ({ssel, sclk, mosi, busy, data_valid} == 5'b10100 && data_received == '0
                && {ssel1, sclk1, busy1} == 3'b100)
                idle_ok++;
        end
        check("idle_50", idle_ok, 50);

        vecs[0] = '{10'h155, 10'h000, 1'b1, 1'b0, 10'h155, 10'h000};
        vecs[1] = '{10'h155, 10'h2AA, 1'b0, 1'b0, 10'h2AA, 10'h155};
        vecs[2] = '{10'h155, 10'h000, 1'b1, 1'b1, 10'h155, 10'h000};
        vecs[3] = '{10'h3FF, 10'h001, 1'b0, 1'b0, 10'h001, 10'h3FF};
        vecs[4] = '{10'h200, 10'h1FF, 1'b0, 1'b0, 10'h1FF, 10'h200};
        vecs[5] = '{10'h001, 10'h3FE, 1'b0, 1'b1, 10'h3FE, 10'h001};
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].tx, vecs[i].sw, vecs[i].lp, vecs[i].poke,
                      vecs[i].exp_rx, vecs[i].exp_srx, $sformatf("vec%0d", i));
            @(negedge clock);
        end

        // Random frames: received word is whatever the far end sent.
        for (int i = 0; i < 8; i++) begin
            rtx = W'($urandom);
            rsw = W'($urandom);
            rlp = 1'($urandom_range(0, 1));
            run_frame(rtx, rsw, rlp, 1'($urandom_range(0, 1)), rlp ? rtx : rsw, rtx,
                      $sformatf("rnd%0d", i));
        end

        // Reset mid-frame after the 5th sclk rise
        loop_mode = 1'b1;
        @(negedge clock);
        data_transmit = 10'h155;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        rises = 0; prev = sclk; n = 0;
        while (rises < 5 && n < 200) begin
            @(negedge clock);
            n++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        check("midrst_reach", rises, 5);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ssel", ssel, 1'b1);
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dv", data_valid, 1'b0);
        check("midrst_rx", data_received, '0);
        reset = 1'b0;
        dv_late = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (data_valid) dv_late++;
        end
        check("midrst_no_dv", dv_late, 0);
        run_frame(10'h2C3, 10'h13A, 1'b0, 1'b0, 10'h13A, 10'h2C3, "post_rst");

        // HALF_PERIOD=1 back-to-back with start held high
        @(negedge clock);
        data_transmit1 = 10'h3FF;
        start1 = 1'b1;
        frames = 0; low1 = 0; n = 0; dv_at = 0; busy_at = 0; prev_busy1 = 1'b0;
        rx1[0] = '1; rx1[1] = '1; lowc[0] = 0; lowc[1] = 0;
        while (frames < 2 && n < 300) begin
            @(negedge clock);
            n++;
            if (!ssel1) low1++;
            if (busy1 && !prev_busy1 && frames == 1) begin
                busy_at = n;
                start1 = 1'b0;
            end
            prev_busy1 = busy1;
            if (data_valid1) begin
                rx1[frames]  = data_received1;
                lowc[frames] = low1;
                low1 = 0;
                if (frames == 0) begin
                    dv_at = n;
                    data_transmit1 = 10'h000;
                end
                frames++;
            end
        end
        start1 = 1'b0;
        check("hp1_frames", frames, 2);
        check("hp1_latency", dv_at, SSEL_LOW1 + 1);
        check("hp1_gap", busy_at - dv_at, 2);
        check("hp1_rx0", rx1[0], 10'h3FF);
        check("hp1_rx1", rx1[1], 10'h000);
        check("hp1_low0", lowc[0], SSEL_LOW1);
        check("hp1_low1", lowc[1], SSEL_LOW1);
        dv_late = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (data_valid1) dv_late++;
        end
        check("hp1_no_third", dv_late, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
